ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage and EX/MEM pipeline register of the 5-stage MIPS core. It consumes the ID/EX latch signals produced by the fetch/decode front end. It returns the branch decision (`PCSrc`) and the branch target (`EX_MEM_latch`) to instruction fetch. It contains the ALU, the branch-target adder, destination-register selection, and a 32-cycle iterative signed multiplier with HI/LO registers that stalls the front end while busy.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `WB_ctrl`  in  2  {RegWrite, MemtoReg}.
- `Mem_ctrl`  in  3  {Branch, MemRead, MemWrite}.
- `EX_ctrl`  in  4  {RegDst, ALUOp[1:0], ALUSrc}.
- `EX_adder`  in  32  PC+4 of the instruction.
- `EX_ALU`  in  32  rs read data.
- `EXMux0_latch`  in  32  rt read data.
- `IR_out`  in  32  sign-extended immediate; bits [5:0] are funct.
- `EXMux0`  in  5  rt field.
- `EXMux1`  in  5  rd field.
- `stall`  out  1  high while the multiplier is busy; freezes PC, IF/ID and ID/EX upstream.
- `PCSrc`  out  1  Branch_q & zero_q (combinational from registers).
- `EX_MEM_latch`  out  32  registered branch target.
- `mem_wb_ctrl`  out  2  registered WB_ctrl.
- `mem_ctrl`  out  3  registered Mem_ctrl.
- `alu_result`  out  32  registered ALU result / memory address.
- `zero`  out  1  registered (ALU result == 0).
- `store_data`  out  32  registered rt data.
- `dest_reg`  out  5  registered destination register: rd if RegDst, else rt.

## Operation
- ALU operand B = ALUSrc ? IR_out : EXMux0_latch.
- Branch target = EX_adder + (IR_out << 2), truncated to 32 bits.
- ALUOp encoding:
  - 00 → add.
  - 01 → sub.
  - 11 → add.
  - 10 → decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x10 MFHI, 0x12 MFLO, 0x18 MULT.
  - Any other funct gives result 0.
- Add and sub wrap modulo 2^32; overflow is ignored.
- FSM states: IDLE and MUL.
  - IDLE → MUL when ALUOp=10 and funct=0x18 at a clock edge.
  - At that edge, latch |rs| and |rt| and their sign XOR, clear the 64-bit product, and set count=0.
  - The EX/MEM register loads a bubble: all ctrl fields 0, data fields don't-care but driven 0.
- MUL state:
  - Each cycle: one shift-add step; count increments.
  - At count=31, the final step completes; HI/LO load the product, two's-complement negated if the sign XOR is 1; FSM → IDLE.
  - Every cycle in MUL loads a bubble into EX/MEM. ID/EX inputs are held upstream and ignored.
- MFHI / MFLO read HI / LO as registered. A MULT issued back-to-back with MFLO still returns the new value because of the stall.
- Reset, asynchronous at any time including mid-multiply:
  - FSM → IDLE, stall=0, HI=LO=0.
  - All EX/MEM outputs 0, so PCSrc=0.

## Timing
- Non-MULT instruction present at edge T: EX/MEM outputs are valid after T, one-cycle latency. PCSrc is valid in the same cycle as mem_ctrl.
- MULT present at edge T0:
  - stall is high from T0 through T0+32, i.e. 32 cycles, and falls at edge T0+32.
  - HI/LO are valid after edge T0+32.
  - The held successor instruction is captured at edge T0+33.
- `stall` is registered (equal to state==MUL); there is no combinational path from inputs to stall.
- A MULT presented while in MUL is not started; it is captured only after returning to IDLE.

## Structure
- Shared package `mips_pkg` holds:
  - ALUOp codes.
  - Funct constants (ADD, SUB, AND, OR, SLT, MFHI, MFLO, MULT).
  - Ctrl field bit positions.
  - FSM state enum.
- Sub-module `seq_multiplier`: 32×32 signed iterative multiplier with start/busy/done and a 64-bit product output. `ex_stage` instantiates it and owns HI/LO.

## Test plan
- Reset mid-MULT at cycle 10 → stall=0 immediately, HI=LO=0, all EX/MEM outputs 0.
- R-type add: rs=0x7FFFFFFF, rt=1, RegDst=1, rd=5 → next cycle alu_result=0x80000000, dest_reg=5, zero=0.
- beq: rs=rt=0x1234, Branch=1, EX_adder=0x100, imm=0xFFFFFFFE → PCSrc=1, EX_MEM_latch=0xF8.
- slt: rs=0xFFFFFFFF, rt=1 → alu_result=1. lw with ALUSrc, imm=8, rs=0x1000 → alu_result=0x1008, dest_reg=rt.
- MULT -3 × 7, then MFLO, then MFHI:
  - stall is high exactly 32 cycles.
  - MFLO result = 0xFFFFFFEB.
  - MFHI result = 0xFFFFFFFF.
  - EX/MEM holds bubbles during the stall.
- Undefined funct 0x3F with ALUOp=10 → alu_result=0, zero=1, ctrl fields passed through.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp codes, funct values,
// control-field bit positions and the multiplier state enum.
package mips_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ADDI  = 2'b11;

   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
   localparam logic [5:0] FUNCT_MULT = 6'h18;

   // Mem_ctrl = {Branch, MemRead, MemWrite}
   localparam int MEM_BRANCH = 2;
   // EX_ctrl = {RegDst, ALUOp[1:0], ALUSrc}
   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative signed multiplier: magnitudes are multiplied one bit per cycle
// with shift-add, and the sign is applied on the final step.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched on the start edge
// ST_MUL  | one shift-add step per cycle, WIDTH steps total
import mips_pkg::*;

module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mul_state_e         state_q, state_d;
   logic [CW-1:0]      count_q;
   logic [WIDTH-1:0]   a_abs_q, b_abs_q, a_abs, b_abs;
   logic               neg_q;
   logic [2*WIDTH-1:0] acc_q, acc_next, partial;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_MUL;
         ST_MUL:  if (count_q == LAST) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // status outputs; done marks the edge on which the final product is valid
   always_comb begin
      busy = (state_q == ST_MUL);
      done = (state_q == ST_MUL) && (count_q == LAST);
   end

   // operand magnitudes, current partial product and signed result
   always_comb begin
      a_abs    = a[WIDTH-1] ? ('0 - a) : a;
      b_abs    = b[WIDTH-1] ? ('0 - b) : b;
      partial  = b_abs_q[count_q] ? ({{WIDTH{1'b0}}, a_abs_q} << count_q) : '0;
      acc_next = acc_q + partial;
      product  = neg_q ? ('0 - acc_next) : acc_next;
   end

   // operand latch and accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_abs_q <= '0;
         b_abs_q <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         count_q <= '0;
      end else if (state_q == ST_IDLE) begin
         if (start) begin
            a_abs_q <= a_abs;
            b_abs_q <= b_abs;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_q   <= '0;
            count_q <= '0;
         end
      end else begin
         acc_q   <= acc_next;
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage and EX/MEM pipeline register: ALU, branch-target adder,
// destination select, and HI/LO fed by the iterative multiplier.
import mips_pkg::*;

module ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       WB_ctrl,
   input  logic [2:0]       Mem_ctrl,
   input  logic [3:0]       EX_ctrl,
   input  logic [WIDTH-1:0] EX_adder,
   input  logic [WIDTH-1:0] EX_ALU,
   input  logic [WIDTH-1:0] EXMux0_latch,
   input  logic [WIDTH-1:0] IR_out,
   input  logic [4:0]       EXMux0,
   input  logic [4:0]       EXMux1,
   output logic             stall,
   output logic             PCSrc,
   output logic [WIDTH-1:0] EX_MEM_latch,
   output logic [1:0]       mem_wb_ctrl,
   output logic [2:0]       mem_ctrl,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [WIDTH-1:0] store_data,
   output logic [4:0]       dest_reg
);

   logic [1:0]         alu_op;
   logic [5:0]         funct;
   logic [WIDTH-1:0]   op_b, alu_y, branch_target;
   logic               is_mult, bubble;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   hi_q, lo_q;

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (is_mult),
      .a       (EX_ALU),
      .b       (EXMux0_latch),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // ALU, operand select and branch target
   always_comb begin
      alu_op        = EX_ctrl[EX_ALUOP_HI:EX_ALUOP_LO];
      funct         = IR_out[5:0];
      op_b          = EX_ctrl[EX_ALUSRC] ? IR_out : EXMux0_latch;
      branch_target = EX_adder + {IR_out[WIDTH-3:0], 2'b00};
      is_mult       = (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MULT);
      alu_y         = '0;
      unique case (alu_op)
         ALUOP_ADD, ALUOP_ADDI: alu_y = EX_ALU + op_b;
         ALUOP_SUB:             alu_y = EX_ALU - op_b;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:  alu_y = EX_ALU + op_b;
               FUNCT_SUB:  alu_y = EX_ALU - op_b;
               FUNCT_AND:  alu_y = EX_ALU & op_b;
               FUNCT_OR:   alu_y = EX_ALU | op_b;
               FUNCT_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(EX_ALU) < $signed(op_b))};
               FUNCT_MFHI: alu_y = hi_q;
               FUNCT_MFLO: alu_y = lo_q;
               FUNCT_MULT: alu_y = '0;
               default:    alu_y = '0;
            endcase
         end
         default: alu_y = '0;
      endcase
   end

   // a MULT on the start edge and every multiplying cycle push a bubble
   always_comb begin
      bubble = is_mult | mul_busy;
      stall  = mul_busy;
      PCSrc  = mem_ctrl[MEM_BRANCH] & zero;
   end

   // HI/LO take the signed product on the multiplier's final step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (mul_done) begin
         hi_q <= mul_product[2*WIDTH-1:WIDTH];
         lo_q <= mul_product[WIDTH-1:0];
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         EX_MEM_latch <= '0;
         mem_wb_ctrl  <= '0;
         mem_ctrl     <= '0;
         alu_result   <= '0;
         zero         <= 1'b0;
         store_data   <= '0;
         dest_reg     <= '0;
      end else if (bubble) begin
         EX_MEM_latch <= '0;
         mem_wb_ctrl  <= '0;
         mem_ctrl     <= '0;
         alu_result   <= '0;
         zero         <= 1'b0;
         store_data   <= '0;
         dest_reg     <= '0;
      end else begin
         EX_MEM_latch <= branch_target;
         mem_wb_ctrl  <= WB_ctrl;
         mem_ctrl     <= Mem_ctrl;
         alu_result   <= alu_y;
         zero         <= (alu_y == '0);
         store_data   <= EXMux0_latch;
         dest_reg     <= EX_ctrl[EX_REGDST] ? EXMux1 : EXMux0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations plus
// randomized instruction streams checked every cycle against a model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  WB_ctrl = '0;
   logic [2:0]  Mem_ctrl = '0;
   logic [3:0]  EX_ctrl = '0;
   logic [31:0] EX_adder = '0, EX_ALU = '0, EXMux0_latch = '0, IR_out = '0;
   logic [4:0]  EXMux0 = '0, EXMux1 = '0;
   logic        stall, PCSrc, zero;
   logic [31:0] EX_MEM_latch, alu_result, store_data;
   logic [1:0]  mem_wb_ctrl;
   logic [2:0]  mem_ctrl;
   logic [4:0]  dest_reg;

   always #5 clk = ~clk;

   ex_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .WB_ctrl(WB_ctrl), .Mem_ctrl(Mem_ctrl),
      .EX_ctrl(EX_ctrl), .EX_adder(EX_adder), .EX_ALU(EX_ALU),
      .EXMux0_latch(EXMux0_latch), .IR_out(IR_out), .EXMux0(EXMux0),
      .EXMux1(EXMux1), .stall(stall), .PCSrc(PCSrc), .EX_MEM_latch(EX_MEM_latch),
      .mem_wb_ctrl(mem_wb_ctrl), .mem_ctrl(mem_ctrl), .alu_result(alu_result),
      .zero(zero), .store_data(store_data), .dest_reg(dest_reg)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int          mul_left;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   logic [31:0] e_alu, e_tgt, e_store;
   logic        e_zero, e_stall;
   logic [1:0]  e_wb;
   logic [2:0]  e_mem;
   logic [4:0]  e_dest;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mul_left = 0;
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      e_alu = '0; e_tgt = '0; e_store = '0; e_zero = 1'b0; e_stall = 1'b0;
      e_wb = '0; e_mem = '0; e_dest = '0;
   endtask

   task automatic model_bubble();
      e_alu = '0; e_tgt = '0; e_store = '0; e_zero = 1'b0;
      e_wb = '0; e_mem = '0; e_dest = '0;
   endtask

   // what the EX/MEM register must hold after the coming edge
   task automatic model_step();
      logic [31:0] b, r;
      longint pa, pb, p;
      if (mul_left > 0) begin
         model_bubble();
         mul_left--;
         if (mul_left == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (EX_ctrl[2:1] == 2'b10 && IR_out[5:0] == 6'h18) begin
         model_bubble();
         pa = longint'($signed(EX_ALU));
         pb = longint'($signed(EXMux0_latch));
         p  = pa * pb;
         p_hi = p[63:32];
         p_lo = p[31:0];
         mul_left = 32;
      end else begin
         b = EX_ctrl[0] ? IR_out : EXMux0_latch;
         case (EX_ctrl[2:1])
            2'b01: r = EX_ALU - b;
            2'b10: begin
               case (IR_out[5:0])
                  6'h20: r = EX_ALU + b;
                  6'h22: r = EX_ALU - b;
                  6'h24: r = EX_ALU & b;
                  6'h25: r = EX_ALU | b;
                  6'h2A: r = ($signed(EX_ALU) < $signed(b)) ? 32'd1 : 32'd0;
                  6'h10: r = m_hi;
                  6'h12: r = m_lo;
                  default: r = 32'd0;
               endcase
            end
            default: r = EX_ALU + b;
         endcase
         e_alu   = r;
         e_zero  = (r == 32'd0);
         e_tgt   = EX_adder + IR_out * 32'd4;
         e_wb    = WB_ctrl;
         e_mem   = Mem_ctrl;
         e_store = EXMux0_latch;
         e_dest  = EX_ctrl[3] ? EXMux1 : EXMux0;
      end
      e_stall = (mul_left > 0);
   endtask

   task automatic compare_all();
      check("stall",      {31'd0, stall},      {31'd0, e_stall});
      check("PCSrc",      {31'd0, PCSrc},      {31'd0, e_mem[2] & e_zero});
      check("target",     EX_MEM_latch,        e_tgt);
      check("mem_wb",     {30'd0, mem_wb_ctrl}, {30'd0, e_wb});
      check("mem_ctrl",   {29'd0, mem_ctrl},   {29'd0, e_mem});
      check("alu_result", alu_result,          e_alu);
      check("zero",       {31'd0, zero},       {31'd0, e_zero});
      check("store_data", store_data,          e_store);
      check("dest_reg",   {27'd0, dest_reg},   {27'd0, e_dest});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic apply(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                        input logic [31:0] pc4, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [4:0] rtf, input logic [4:0] rdf);
      WB_ctrl = wb; Mem_ctrl = mem; EX_ctrl = ex; EX_adder = pc4;
      EX_ALU = rs; EXMux0_latch = rt; IR_out = imm; EXMux0 = rtf; EXMux1 = rdf;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_pcsrc"}, {31'd0, PCSrc}, 32'd0);
      check({tag, "_target"}, EX_MEM_latch, 32'd0);
      check({tag, "_ctrl"}, {27'd0, mem_wb_ctrl, mem_ctrl}, 32'd0);
      check({tag, "_alu"}, alu_result, 32'd0);
      check({tag, "_zero"}, {31'd0, zero}, 32'd0);
      check({tag, "_store"}, store_data, 32'd0);
      check({tag, "_dest"}, {27'd0, dest_reg}, 32'd0);
   endtask

   logic [5:0] funct_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

   initial begin
      int stall_cnt;
      int k;
      logic [31:0] rs, rt, imm;
      logic [5:0]  fn;

      model_reset();
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // add with signed overflow wrap, rd destination
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 5'd2, 5'd5);
      tick();
      check("model_add", e_alu, 32'h80000000);
      check("add_alu", alu_result, 32'h80000000);
      check("add_dest", {27'd0, dest_reg}, 32'd5);
      check("add_zero", {31'd0, zero}, 32'd0);

      // beq taken with a backward offset
      apply(2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFE, 5'd1, 5'd2);
      tick();
      check("model_beq_tgt", e_tgt, 32'hF8);
      check("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
      check("beq_target", EX_MEM_latch, 32'hF8);

      // slt signed
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h2A, 5'd3, 5'd4);
      tick();
      check("slt_alu", alu_result, 32'd1);

      // lw address with immediate, rt destination
      apply(2'b11, 3'b010, 4'b0001, 32'h0, 32'h1000, 32'hDEAD, 32'h8, 5'd9, 5'd3);
      tick();
      check("lw_alu", alu_result, 32'h1008);
      check("lw_dest", {27'd0, dest_reg}, 32'd9);

      // undefined funct
      apply(2'b10, 3'b001, 4'b1100, 32'h0, 32'h55, 32'h66, 32'h3F, 5'd1, 5'd7);
      tick();
      check("undef_alu", alu_result, 32'd0);
      check("undef_zero", {31'd0, zero}, 32'd1);
      check("undef_ctrl", {27'd0, mem_wb_ctrl, mem_ctrl}, {27'd0, 2'b10, 3'b001});

      // MULT -3 x 7, successor MFLO held upstream, then MFHI
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFD, 32'h7, 32'h18, 5'd0, 5'd0);
      tick();
      stall_cnt = int'(stall);
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd8);
      for (int i = 0; i < 32; i++) begin
         tick();
         stall_cnt += int'(stall);
         if (i == 15) check("mul_bubble", {27'd0, mem_wb_ctrl, mem_ctrl}, 32'd0);
      end
      check("mul_stall_cycles", stall_cnt, 32'd32);
      tick();
      check("model_mflo", e_alu, 32'hFFFFFFEB);
      check("mflo_alu", alu_result, 32'hFFFFFFEB);
      check("mflo_dest", {27'd0, dest_reg}, 32'd8);
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd9);
      tick();
      check("mfhi_alu", alu_result, 32'hFFFFFFFF);

      // reset in the middle of a multiply
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'd12345, 32'd678, 32'h18, 5'd0, 5'd0);
      for (int i = 0; i < 10; i++) tick();
      check("mid_stall_before", {31'd0, stall}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      model_reset();
      #1 rst_n = 1'b1;
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd1);
      tick();
      check("rst_hi", alu_result, 32'd0);
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd1);
      tick();
      check("rst_lo", alu_result, 32'd0);

      // randomized instruction stream; inputs also wander while stalled
      for (int n = 0; n < 400; n++) begin
         k  = int'($urandom_range(0, 11));
         rs = $urandom;
         rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
         if ($urandom_range(0, 3) == 0) rs = rs & 32'h8000000F;
         imm = $urandom_range(0, 1) ? 32'($signed(16'($urandom))) : $urandom;
         fn  = funct_tab[$urandom_range(0, 5)];
         if (k == 0)      fn = 6'h18;
         else if (k == 1) fn = 6'h10;
         else if (k == 2) fn = 6'h12;
         imm = {imm[31:6], fn};
         if (k <= 2 || k >= 9)
            apply(2'($urandom), 3'($urandom), {1'($urandom), 2'b10, 1'b0}, $urandom,
                  rs, rt, imm, 5'($urandom), 5'($urandom));
         else
            apply(2'($urandom), 3'($urandom), 4'($urandom), $urandom,
                  rs, rt, imm, 5'($urandom), 5'($urandom));
         tick();
      end

      // drain any multiply in flight and read its result
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd1);
      for (int i = 0; i < 34; i++) tick();
      apply(2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
